// File: rtl/MD_pkg.sv
// Shared widths for the MD force pipeline.
package MD_pkg;
  parameter int FLOAT_STRUCT_WIDTH = 96;
  parameter int PARTICLE_ID_WIDTH  = 4;
endpackage

// File: rtl/force_readout_ctrl_if.sv
// Cache read port plus the force stream towards motion update; master is the readout controller.
interface force_readout_ctrl_if;
  import MD_pkg::*;

  logic [PARTICLE_ID_WIDTH-1:0]  o_MU_rd_addr;
  logic                          o_MU_rd_en;
  logic [FLOAT_STRUCT_WIDTH-1:0] i_frc;
  logic                          i_frc_valid;
  logic [FLOAT_STRUCT_WIDTH-1:0] o_mu_frc;
  logic [PARTICLE_ID_WIDTH-1:0]  o_mu_parid;
  logic                          o_mu_valid;
  logic                          i_mu_ready;

  modport master (
    output o_MU_rd_addr, o_MU_rd_en, o_mu_frc, o_mu_parid, o_mu_valid,
    input  i_frc, i_frc_valid, i_mu_ready
  );

  modport slave (
    input  o_MU_rd_addr, o_MU_rd_en, o_mu_frc, o_mu_parid, o_mu_valid,
    output i_frc, i_frc_valid, i_mu_ready
  );
endinterface

// File: rtl/force_readout_ctrl.sv
// Waits for the force buffer to drain, then read-clears every cache entry in address order into a 2-slot FIFO
// feeding motion update; 2-cycle read-to-valid latency, reads throttled by a 2-credit loop when i_mu_ready is low.
module force_readout_ctrl
  import MD_pkg::*;
#(
  parameter int NUM_PARTICLES = 64,
  parameter int DRAIN_CYCLES  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_buf_empty,
  force_readout_ctrl_if.master bus,
  output logic                 o_frc_block,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int AW = PARTICLE_ID_WIDTH;
  localparam int FW = FLOAT_STRUCT_WIDTH;
  localparam int DW = FW + AW;
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_PARTICLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, DRAIN, READ, FLUSH, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   drain_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   addr_dly_q;
  logic [DW-1:0]   fifo_q [2];
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [1:0]      cnt_q;
  logic [1:0]      infl_q;
  logic            busy_q;
  logic            blk_q;
  logic            done_q;

  logic            push;
  logic            pop;
  logic            issue;
  logic [2:0]      credit_used;
  logic [DW-1:0]   head;

  assign pop  = (cnt_q != 2'd0) && bus.i_mu_ready;
  assign push = bus.i_frc_valid && ((state_q == READ) || (state_q == FLUSH));

  // A head leaving this cycle frees its slot before the new read's data lands, which is what allows one read per cycle.
  assign credit_used = {1'b0, cnt_q} + {1'b0, infl_q} - {2'b00, pop};
  assign issue       = (state_q == READ) && (credit_used < 3'd2);

  assign head             = fifo_q[rd_ptr_q];
  assign bus.o_MU_rd_en   = issue;
  assign bus.o_MU_rd_addr = addr_q;
  assign bus.o_mu_valid   = (cnt_q != 2'd0);
  assign bus.o_mu_frc     = bus.o_mu_valid ? head[DW-1:AW] : '0;
  assign bus.o_mu_parid   = bus.o_mu_valid ? head[AW-1:0]  : '0;
  assign o_frc_block      = blk_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      drain_q    <= '0;
      addr_q     <= '0;
      addr_dly_q <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      infl_q     <= 2'd0;
      busy_q     <= 1'b0;
      blk_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      addr_dly_q <= addr_q;
      infl_q     <= infl_q + {1'b0, issue} - {1'b0, push};
      cnt_q      <= cnt_q + {1'b0, push} - {1'b0, pop};
      done_q     <= 1'b0;
      if (push) begin
        fifo_q[wr_ptr_q] <= {bus.i_frc, addr_dly_q};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end

      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q <= DRAIN;
            drain_q <= '0;
            busy_q  <= 1'b1;
            blk_q   <= 1'b1;
          end
        end
        DRAIN: begin
          if (!i_buf_empty) begin
            drain_q <= '0;
          end else if (drain_q == DRAIN_LAST) begin
            state_q <= READ;
            drain_q <= '0;
            addr_q  <= '0;
          end else begin
            drain_q <= drain_q + CW'(1);
          end
        end
        READ: begin
          // The address parks on the last entry so a full-range id space never wraps.
          if (issue) begin
            if (addr_q == LAST_ADDR) begin
              state_q <= FLUSH;
            end else begin
              addr_q <= addr_q + AW'(1);
            end
          end
        end
        FLUSH: begin
          if ((cnt_q == 2'd0) && (infl_q == 2'd0)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          addr_q  <= '0;
          busy_q  <= 1'b0;
          blk_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_force_readout_ctrl.sv
// Directed bench: three controller sizes (4, 8, full id range) behind a modelled read-clear cache.
module tb_force_readout_ctrl;
  import MD_pkg::*;

  localparam int AW    = PARTICLE_ID_WIDTH;
  localparam int FW    = FLOAT_STRUCT_WIDTH;
  localparam int NFULL = 2**AW;

  logic clk = 1'b0;
  logic rst;
  logic buf_empty;
  logic ready;
  logic spur4;
  logic st4, st8, st16;
  logic blk4, blk8, blk16;
  logic busy4, busy8, busy16;
  logic done4, done8, done16;

  int errors = 0;
  int checks = 0;
  int sel = 4;

  force_readout_ctrl_if ifc4 ();
  force_readout_ctrl_if ifc8 ();
  force_readout_ctrl_if ifc16 ();

  always #5 clk = ~clk;

  force_readout_ctrl #(.NUM_PARTICLES(4), .DRAIN_CYCLES(8)) u4 (
    .clk(clk), .rst(rst), .i_start(st4), .i_buf_empty(buf_empty), .bus(ifc4.master),
    .o_frc_block(blk4), .o_busy(busy4), .o_done(done4));
  force_readout_ctrl #(.NUM_PARTICLES(8), .DRAIN_CYCLES(8)) u8 (
    .clk(clk), .rst(rst), .i_start(st8), .i_buf_empty(buf_empty), .bus(ifc8.master),
    .o_frc_block(blk8), .o_busy(busy8), .o_done(done8));
  force_readout_ctrl #(.NUM_PARTICLES(NFULL), .DRAIN_CYCLES(8)) u16 (
    .clk(clk), .rst(rst), .i_start(st16), .i_buf_empty(buf_empty), .bus(ifc16.master),
    .o_frc_block(blk16), .o_busy(busy16), .o_done(done16));

  function automatic logic [FW-1:0] frc_of(input logic [AW-1:0] a);
    logic [FW-1:0] v;
    v = '0;
    v[31:0]        = 32'hC0DE_0000 | 32'(a);
    v[63:32]       = ~32'(a);
    v[FW-1 -: 32]  = 32'hF00D_0000 + 32'(a);
    return v;
  endfunction

  assign ifc4.i_mu_ready  = ready;
  assign ifc8.i_mu_ready  = ready;
  assign ifc16.i_mu_ready = ready;

  // Cache model: data and valid one cycle after the read strobe.
  always @(posedge clk) begin
    if (!rst) begin
      ifc4.i_frc_valid  <= 1'b0;
      ifc8.i_frc_valid  <= 1'b0;
      ifc16.i_frc_valid <= 1'b0;
      ifc4.i_frc        <= '0;
      ifc8.i_frc        <= '0;
      ifc16.i_frc       <= '0;
    end else begin
      ifc4.i_frc_valid  <= ifc4.o_MU_rd_en | spur4;
      ifc8.i_frc_valid  <= ifc8.o_MU_rd_en;
      ifc16.i_frc_valid <= ifc16.o_MU_rd_en;
      ifc4.i_frc        <= frc_of(ifc4.o_MU_rd_addr);
      ifc8.i_frc        <= frc_of(ifc8.o_MU_rd_addr);
      ifc16.i_frc       <= frc_of(ifc16.o_MU_rd_addr);
    end
  end

  logic          m_en, m_valid, m_blk, m_busy, m_done;
  logic [AW-1:0] m_addr, m_parid;
  logic [FW-1:0] m_frc;

  always_comb begin
    m_en = ifc4.o_MU_rd_en; m_addr = ifc4.o_MU_rd_addr; m_valid = ifc4.o_mu_valid;
    m_parid = ifc4.o_mu_parid; m_frc = ifc4.o_mu_frc; m_blk = blk4; m_busy = busy4; m_done = done4;
    if (sel == 8) begin
      m_en = ifc8.o_MU_rd_en; m_addr = ifc8.o_MU_rd_addr; m_valid = ifc8.o_mu_valid;
      m_parid = ifc8.o_mu_parid; m_frc = ifc8.o_mu_frc; m_blk = blk8; m_busy = busy8; m_done = done8;
    end else if (sel == 16) begin
      m_en = ifc16.o_MU_rd_en; m_addr = ifc16.o_MU_rd_addr; m_valid = ifc16.o_mu_valid;
      m_parid = ifc16.o_mu_parid; m_frc = ifc16.o_mu_frc; m_blk = blk16; m_busy = busy16; m_done = done16;
    end
  end

  task automatic set_start(input logic v);
    st4  = v && (sel == 4);
    st8  = v && (sel == 8);
    st16 = v && (sel == 16);
  endtask

  task automatic test_reset();
    sel = 8; rst = 1'b0; buf_empty = 1'b1; ready = 1'b1; spur4 = 1'b0; set_start(1'b0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({m_en, m_blk, m_valid, m_busy, m_done} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {m_en, m_blk, m_valid, m_busy, m_done});
    end
    checks++;
    if (m_addr !== '0 || m_parid !== '0) begin
      errors++; $display("FAIL reset_addr: addr=%0d parid=%0d want 0 0", m_addr, m_parid);
    end
    checks++;
    if (m_frc !== '0) begin
      errors++; $display("FAIL reset_frc: got %h want 0", m_frc);
    end
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (m_busy !== 1'b0 || m_en !== 1'b0 || m_blk !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b en=%b blk=%b want 0 0 0", m_busy, m_en, m_blk);
    end
  endtask

  task automatic test_nominal();
    int nrd = 0, nout = 0, ndone = 0;
    sel = 4; ready = 1'b1; buf_empty = 1'b1;
    @(negedge clk); set_start(1'b1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); set_start(1'b0); #1;
      if (k == 1) begin
        checks++;
        if (m_blk !== 1'b1 || m_busy !== 1'b1) begin
          errors++; $display("FAIL nom_block_on: blk=%b busy=%b want 1 1", m_blk, m_busy);
        end
      end
      if (m_en === 1'b1) begin
        checks++;
        if (m_addr !== AW'(nrd) || k != 9 + nrd) begin
          errors++; $display("FAIL nom_rd: addr=%0d cycle=%0d want addr=%0d cycle=%0d", m_addr, k, nrd, 9 + nrd);
        end
        nrd++;
      end
      if (m_valid === 1'b1) begin
        checks++;
        if (m_parid !== AW'(nout) || m_frc !== frc_of(AW'(nout)) || k != 11 + nout) begin
          errors++; $display("FAIL nom_out: parid=%0d cycle=%0d want parid=%0d cycle=%0d", m_parid, k, nout, 11 + nout);
        end
        nout++;
      end
      if (m_done === 1'b1) begin
        checks++;
        if (k <= 14) begin
          errors++; $display("FAIL nom_done_cycle: got cycle %0d want after 14", k);
        end
        ndone++;
      end
    end
    checks++;
    if (nrd != 4 || nout != 4 || ndone != 1) begin
      errors++; $display("FAIL nom_counts: rd=%0d out=%0d done=%0d want 4 4 1", nrd, nout, ndone);
    end
    checks++;
    if (m_blk !== 1'b0 || m_busy !== 1'b0) begin
      errors++; $display("FAIL nom_block_off: blk=%b busy=%b want 0 0", m_blk, m_busy);
    end
  endtask

  task automatic test_drain_restart();
    int nrd = 0, first = -1, ndone = 0;
    sel = 4; ready = 1'b1;
    @(negedge clk); buf_empty = 1'b1; set_start(1'b1);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk); set_start(1'b0); buf_empty = (k != 6); #1;
      if (m_en === 1'b1) begin
        if (first < 0) first = k;
        checks++;
        if (m_addr !== AW'(nrd)) begin
          errors++; $display("FAIL drain_addr: got %0d want %0d", m_addr, nrd);
        end
        nrd++;
      end
      if (m_done === 1'b1) ndone++;
    end
    checks++;
    if (first != 15) begin
      errors++; $display("FAIL drain_first_read: cycle=%0d want 15", first);
    end
    checks++;
    if (nrd != 4 || ndone != 1) begin
      errors++; $display("FAIL drain_counts: rd=%0d done=%0d want 4 1", nrd, ndone);
    end
    buf_empty = 1'b1;
  endtask

  task automatic test_spurious_valid();
    int seen = 0;
    sel = 4;
    @(negedge clk); spur4 = 1'b1;
    @(negedge clk); spur4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (m_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL spurious_valid: o_mu_valid high %0d cycles want 0", seen);
    end
  endtask

  task automatic test_ignored_start();
    int nrd = 0, ndone = 0;
    sel = 4; ready = 1'b1;
    @(negedge clk); set_start(1'b1);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk); set_start(k == 10); #1;
      if (m_en === 1'b1) begin
        checks++;
        if (m_addr !== AW'(nrd) || k != 9 + nrd) begin
          errors++; $display("FAIL ign_rd: addr=%0d cycle=%0d want addr=%0d cycle=%0d", m_addr, k, nrd, 9 + nrd);
        end
        nrd++;
      end
      if (m_done === 1'b1) ndone++;
    end
    checks++;
    if (nrd != 4 || ndone != 1 || m_busy !== 1'b0) begin
      errors++; $display("FAIL ign_counts: rd=%0d done=%0d busy=%b want 4 1 0", nrd, ndone, m_busy);
    end
  endtask

  task automatic test_backpressure();
    int issued = 0, popped = 0, ndone = 0;
    sel = 8; ready = 1'b1;
    @(negedge clk); set_start(1'b1);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk); set_start(1'b0); ready = !(k >= 10 && k < 20); #1;
      if (m_en === 1'b1) begin
        checks++;
        if (m_addr !== AW'(issued)) begin
          errors++; $display("FAIL bp_addr: got %0d want %0d", m_addr, issued);
        end
        issued++;
      end
      if (m_valid === 1'b1) begin
        checks++;
        if (m_parid !== AW'(popped) || m_frc !== frc_of(AW'(popped))) begin
          errors++; $display("FAIL bp_head: cycle=%0d parid=%0d want %0d", k, m_parid, popped);
        end
        if (ready) popped++;
      end
      if (k >= 10 && k < 20) begin
        checks++;
        if (issued - popped > 2) begin
          errors++; $display("FAIL bp_outstanding: cycle=%0d got %0d want <=2", k, issued - popped);
        end
      end
      if (m_done === 1'b1) ndone++;
    end
    checks++;
    if (issued != 8 || popped != 8 || ndone != 1) begin
      errors++; $display("FAIL bp_counts: rd=%0d out=%0d done=%0d want 8 8 1", issued, popped, ndone);
    end
    ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int hit = 0, stray = 0, nrd = 0, nout = 0, ndone = 0;
    sel = 8; ready = 1'b1;
    @(negedge clk); set_start(1'b1);
    for (int k = 1; k <= 20 && hit == 0; k++) begin
      @(negedge clk); set_start(1'b0); #1;
      if (m_en === 1'b1 && m_addr === AW'(2)) hit = 1;
    end
    checks++;
    if (hit == 0) begin
      errors++; $display("FAIL rstmid_wait: address 2 not issued within 20 cycles");
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if ({m_en, m_blk, m_valid, m_busy, m_done} !== 5'b0 || m_addr !== '0 || m_parid !== '0 || m_frc !== '0) begin
      errors++; $display("FAIL rstmid_outputs: ctl=%b addr=%0d parid=%0d want all 0",
                         {m_en, m_blk, m_valid, m_busy, m_done}, m_addr, m_parid);
    end
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      if (m_en !== 1'b0 || m_busy !== 1'b0 || m_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL rstmid_quiet: activity in %0d cycles want 0", stray);
    end
    @(negedge clk); set_start(1'b1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk); set_start(1'b0); #1;
      if (m_en === 1'b1) begin
        checks++;
        if (m_addr !== AW'(nrd) || k != 9 + nrd) begin
          errors++; $display("FAIL rstmid_rd: addr=%0d cycle=%0d want addr=%0d cycle=%0d", m_addr, k, nrd, 9 + nrd);
        end
        nrd++;
      end
      if (m_valid === 1'b1) begin
        checks++;
        if (m_parid !== AW'(nout)) begin
          errors++; $display("FAIL rstmid_out: parid=%0d want %0d", m_parid, nout);
        end
        nout++;
      end
      if (m_done === 1'b1) ndone++;
    end
    checks++;
    if (nrd != 8 || nout != 8 || ndone != 1) begin
      errors++; $display("FAIL rstmid_counts: rd=%0d out=%0d done=%0d want 8 8 1", nrd, nout, ndone);
    end
  endtask

  task automatic test_full_range();
    int nrd = 0, nout = 0, ndone = 0;
    sel = 16; ready = 1'b1;
    @(negedge clk); set_start(1'b1);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk); set_start(1'b0); #1;
      if (m_en === 1'b1) begin
        checks++;
        if (m_addr !== AW'(nrd) || k != 9 + nrd) begin
          errors++; $display("FAIL full_rd: addr=%0d cycle=%0d want addr=%0d cycle=%0d", m_addr, k, nrd, 9 + nrd);
        end
        nrd++;
      end
      if (k == 9 + NFULL) begin
        checks++;
        if (m_en !== 1'b0 || m_addr !== {AW{1'b1}} || m_busy !== 1'b1) begin
          errors++; $display("FAIL full_nowrap: en=%b addr=%0d busy=%b want 0 %0d 1", m_en, m_addr, m_busy, NFULL - 1);
        end
      end
      if (m_valid === 1'b1) begin
        checks++;
        if (m_parid !== AW'(nout) || m_frc !== frc_of(AW'(nout))) begin
          errors++; $display("FAIL full_out: parid=%0d want %0d", m_parid, nout);
        end
        nout++;
      end
      if (m_done === 1'b1) ndone++;
    end
    checks++;
    if (nrd != NFULL || nout != NFULL || ndone != 1 || m_busy !== 1'b0) begin
      errors++; $display("FAIL full_counts: rd=%0d out=%0d done=%0d busy=%b want %0d %0d 1 0",
                         nrd, nout, ndone, m_busy, NFULL, NFULL);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_drain_restart();
    test_spurious_valid();
    test_ignored_start();
    test_backpressure();
    test_reset_mid();
    test_full_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
